// File: rtl/ad5328_ch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ad5328_ch_sequencer_if
// Purpose  : Single-word write handshake between the sequencer and the
//            AD5328 serial core.
// Revision : 1.0  initial release
// ============================================================================
interface ad5328_ch_sequencer_if;
    logic        dac_wr_req;
    logic [15:0] dac_wr_data;
    logic        dac_ready;

    modport master (
        output dac_wr_req,
        output dac_wr_data,
        input  dac_ready
    );

    modport slave (
        input  dac_wr_req,
        input  dac_wr_data,
        output dac_ready
    );
endinterface
`default_nettype wire

// File: rtl/ad5328_ch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ad5328_ch_sequencer
// Purpose  : Shadows eight AD5328 channel codes, sends two init words after
//            reset, then streams host-modified channels round-robin.
// Revision : 1.0  initial release
// ============================================================================
module ad5328_ch_sequencer #(
    parameter logic [15:0] INIT_WORD0 = 16'h8000,
    parameter logic [15:0] INIT_WORD1 = 16'hA000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we_i,
    input  logic [2:0]            cfg_ch_i,
    input  logic [11:0]           cfg_val_i,
    ad5328_ch_sequencer_if.master dac,
    output logic                  init_done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_RST_WAIT  = 3'd0,
        S_INIT0     = 3'd1,
        S_INIT1     = 3'd2,
        S_SCAN      = 3'd3,
        S_ISSUE     = 3'd4,
        S_WAIT_BUSY = 3'd5,
        S_WAIT_DONE = 3'd6
    } state_t;

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    logic                chan_q, chan_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          dirty_q, dirty_d;
    logic [7:0][11:0]    shadow_q;
    logic                req_q, req_d;
    logic [15:0]         data_q, data_d;
    logic                init_done_q, init_done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                pick_found;
    logic [2:0]          pick_ch;
    logic [11:0]         pick_val;
    logic [7:0]          clr_mask;
    logic [7:0]          set_mask;
    logic [7:0]          we_mask;

    // Round-robin search: first dirty channel strictly after the last one serviced.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            if (!pick_found && dirty_q[last_q + 3'(i)]) begin
                pick_found = 1'b1;
                pick_ch    = last_q + 3'(i);
            end
        end
    end

    // A host write landing in the decision cycle is forwarded so the word
    // carries the newest code; the dirty clear in ISSUE would otherwise drop it.
    assign pick_val = (cfg_we_i && (cfg_ch_i == pick_ch)) ? cfg_val_i : shadow_q[pick_ch];
    assign we_mask  = cfg_we_i ? (8'd1 << cfg_ch_i) : 8'd0;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        chan_d      = chan_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        req_d       = 1'b0;
        clr_mask    = 8'd0;
        set_mask    = 8'd0;

        case (state_q)
            S_RST_WAIT: begin
                if (dac.dac_ready) begin
                    state_d = S_INIT0;
                end
            end
            S_INIT0: begin
                data_d  = INIT_WORD0;
                chan_d  = 1'b0;
                ret_d   = S_INIT1;
                req_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_INIT1: begin
                data_d  = INIT_WORD1;
                chan_d  = 1'b0;
                ret_d   = S_SCAN;
                req_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_SCAN: begin
                if (pick_found) begin
                    ptr_d   = pick_ch;
                    data_d  = {1'b0, pick_ch, pick_val};
                    chan_d  = 1'b1;
                    ret_d   = S_SCAN;
                    req_d   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (chan_q) begin
                    clr_mask[ptr_q] = 1'b1;
                    last_d          = ptr_q;
                end
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // cnt_q == 0 is the guard cycle right after ISSUE; ready is not sampled.
                if ((cnt_q != '0) && !dac.dac_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    if (chan_q) begin
                        set_mask[ptr_q] = 1'b1;
                    end
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (dac.dac_ready) begin
                    state_d = ret_q;
                    if (!chan_q && (ret_q == S_SCAN)) begin
                        init_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_RST_WAIT;
            end
        endcase

        // Host set wins over a same-cycle clear.
        dirty_d = (dirty_q & ~clr_mask) | set_mask | we_mask;
        busy_d  = (dirty_d != 8'd0) || (state_d != S_SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST_WAIT;
            ret_q       <= S_INIT1;
            chan_q      <= 1'b0;
            ptr_q       <= 3'd0;
            last_q      <= 3'd7;
            cnt_q       <= '0;
            dirty_q     <= 8'd0;
            shadow_q    <= '0;
            req_q       <= 1'b0;
            data_q      <= 16'h0000;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            chan_q      <= chan_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            req_q       <= req_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            if (cfg_we_i) begin
                shadow_q[cfg_ch_i] <= cfg_val_i;
            end
        end
    end

    assign dac.dac_wr_req  = req_q;
    assign dac.dac_wr_data = data_q;
    assign init_done_o     = init_done_q;
    assign busy_o          = busy_q;
    assign err_o           = err_q;

endmodule
`default_nettype wire

// File: doc/ad5328_ch_sequencer.md
# ad5328_ch_sequencer

Upstream feeder for the AD5328 serial core: keeps a shadow copy of all eight 12-bit DAC channel codes, sends the two configuration words once after reset, then streams every channel changed by the host as one 16-bit command at a time. It sits between the register/host logic and the AD5328 serial core. It drives the core's single-word write handshake (write request, data, ready) so the host never waits on the serial link.

## Interface
- `INIT_WORD0`, default 16'h8000: first control word sent after reset (gain/buffer/VDD setup).
- `INIT_WORD1`, default 16'hA000: second control word (LDAC mode).
- `TIMEOUT`, default 255: maximum cycles to wait for `dac_ready` to fall after a request.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `cfg_we`  in  1  host write strobe, one cycle per write.
- `cfg_ch`  in  3  channel index 0..7 (A..H).
- `cfg_val`  in  12  channel code.
- `dac_ready`  in  1  core ready; high when the core is idle or finishing.
- `dac_wr_req`  out  1  one-cycle write request to the core.
- `dac_wr_data`  out  16  command word; stable from the request cycle until the next request.
- `init_done`  out  1  high once both init words have completed.
- `busy`  out  1  high while any channel is dirty or a transfer is in flight.
- `err`  out  1  sticky timeout flag; cleared only by `rst`.

## Operation
- Storage:
  - `shadow[0..7]`: 12 bits each.
  - `dirty[7:0]`: one bit per channel.
  - `ptr`: 3-bit round-robin pointer.
  - `last`: 3-bit index of the last channel serviced.
- Host write `cfg_we`: `shadow[cfg_ch] <= cfg_val` and `dirty[cfg_ch] <= 1`.
  - Accepted in every state, including during init.
  - If it lands in the same cycle that the sequencer clears that channel's dirty bit, set wins. The new value is sent on a later pass.
- Channel word format: `{1'b0, ch[2:0], shadow[ch][11:0]}`.
  - The word is captured into `dac_wr_data` in the ISSUE cycle.
  - Later host writes do not alter a word already issued.
- States:
  - RST_WAIT: wait for `dac_ready`=1, then go to INIT0.
  - INIT0 / INIT1: load INIT_WORD0 / INIT_WORD1 and go to ISSUE. The return target is INIT1 / SCAN respectively.
  - SCAN:
    - If `dirty` is 0, stay in SCAN.
    - Otherwise pick the first set bit searching upward from `last+1`, wrapping 7→0. Set `ptr` to it and go to ISSUE.
  - ISSUE:
    - Pulse `dac_wr_req` for one cycle and drive the word.
    - For a channel word, clear `dirty[ptr]` (subject to set-wins) and set `last <= ptr`.
    - Go to WAIT_BUSY.
  - WAIT_BUSY:
    - `dac_ready`=0 → WAIT_DONE.
    - If TIMEOUT cycles pass without that, set `err`, re-set `dirty[ptr]` for a channel word, and go to the return target.
  - WAIT_DONE: `dac_ready`=1 → return target (INIT1 after INIT0, SCAN after INIT1, SCAN after a channel word).
- `init_done` rises on the WAIT_DONE→SCAN transition that ends INIT1.
- `busy = (dirty != 0) | (state ∉ {SCAN})`. During init `busy` is therefore 1.
- Reset applied mid-transfer returns the block to RST_WAIT.
  - The core is reset from the same source, so no transfer is resumed.

## Timing
- Reset values: `dac_wr_req`=0, `dac_wr_data`=16'h0000, `init_done`=0, `busy`=1, `err`=0.
  - Also reset: `dirty`=0, `shadow`=0, `last`=7, so the first scan starts at channel 0.
- All outputs are registered.
- `dac_wr_req` is never high for two consecutive cycles. At most one request is outstanding.
- `dac_ready` is ignored in the ISSUE cycle and the cycle after it.
  - Reason: the core deasserts ready 2–3 cycles after a request.
  - WAIT_BUSY starts sampling in the second cycle after ISSUE.
- Latency, idle in SCAN: `cfg_we` in cycle N → dirty in N+1 → ISSUE decision in N+1 → `dac_wr_req` high in N+2.
- Back-to-back channels: the next request comes 2 cycles after `dac_ready` returns high (WAIT_DONE → SCAN → ISSUE).
- Multiple writes to the same channel before service collapse into one transfer carrying the latest value.

## Test plan
- Reset, core model with ready=1 → `dac_wr_data`=16'h8000 with one `dac_wr_req` pulse, then 16'hA000; `init_done` rises after the second ready return; no other requests.
- After init, write ch3=12'h5A5 while idle → `dac_wr_req` exactly 2 cycles later with `dac_wr_data`=16'h35A5; `busy` returns to 0 after ready returns.
- Write ch7, ch0, ch2 in consecutive cycles, then ch5 during the ch7 transfer → order 7, 0, 2, 5.
  - Word values are 16'h7xxx, 16'h0xxx, 16'h2xxx, 16'h5xxx.
  - Every request waits for a ready low→high cycle.
- Write ch1=12'h111 then ch1=12'h222 in the ISSUE cycle of ch1 → first word 16'h1111, second word 16'h1222 (set-wins).
- Core model holds ready=1 forever after a request → `err`=1 after TIMEOUT+2 cycles, the channel is re-issued, and `err` stays 1 until `rst`.
- Assert `rst` while in WAIT_DONE → all outputs at reset values next cycle; the init sequence restarts when ready=1.
